// File: rtl/overlay_pkg.sv
// Shared definitions for the overlay blocks: pixel width, emblem sequencer
// state encoding and the per-channel fade function.
package overlay_pkg;

    localparam int unsigned RGB_W = 6;

    typedef enum logic [1:0] {
        EmIdle    = 2'd0,
        EmFadeIn  = 2'd1,
        EmHold    = 2'd2,
        EmFadeOut = 2'd3
    } emblem_state_t;

    // Clamp every 2-bit colour channel to the fade level.
    function automatic logic [RGB_W-1:0] rgb_fade(input logic [RGB_W-1:0] rgb,
                                                  input logic [1:0]       level);
        logic [RGB_W-1:0] res;
        res = '0;
        for (int i = 0; i < int'(RGB_W / 2); i++) begin
            res[2*i +: 2] = (rgb[2*i +: 2] > level) ? level : rgb[2*i +: 2];
        end
        return res;
    endfunction

endpackage

// File: rtl/emblem_bounce.sv
// Horizontal bounce offset for the emblem: off_x walks by BOUNCE_STEP each
// enabled frame, clamping at +/-BOUNCE_LIMIT and reversing direction there.
module emblem_bounce #(
    parameter int unsigned BOUNCE_LIMIT = 64,
    parameter int unsigned BOUNCE_STEP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    output logic signed [8:0] off_x
);

    logic signed [8:0]  off_q, off_d;
    logic               dir_q, dir_d;   // 0: moving right (+), 1: moving left (-)
    logic signed [10:0] lim, neg_lim, step, cur, nxt;

    // Next offset with clamp; arithmetic is widened so the overshoot is visible.
    always_comb begin
        lim     = $signed(11'(BOUNCE_LIMIT));
        neg_lim = -lim;
        step    = $signed(11'(BOUNCE_STEP));
        cur     = $signed({{2{off_q[8]}}, off_q});
        nxt     = dir_q ? (cur - step) : (cur + step);
        off_d   = off_q;
        dir_d   = dir_q;
        if (clr) begin
            off_d = '0;
            dir_d = 1'b0;
        end else if (en) begin
            if (nxt > lim) begin
                off_d = lim[8:0];
                dir_d = ~dir_q;
            end else if (nxt < neg_lim) begin
                off_d = neg_lim[8:0];
                dir_d = ~dir_q;
            end else begin
                off_d = nxt[8:0];
            end
        end
    end

    // Offset/direction state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= '0;
            dir_q <= 1'b0;
        end else begin
            off_q <= off_d;
            dir_q <= dir_d;
        end
    end

    assign off_x = off_q;

endmodule

// File: rtl/emblem_ctrl.sv
// Per-frame fade/hold sequencer for the shield emblem overlay. Translates beam
// coordinates for the emblem generator and mixes its output over the
// background into a registered pixel. All sequencing happens on frame_start.
// Define EMBLEM_CTRL_BOUNCE_EN to enable the horizontal bounce during HOLD.
module emblem_ctrl
    import overlay_pkg::*;
#(
    parameter int unsigned FADE_FRAMES  = 8,
    parameter int unsigned HOLD_FRAMES  = 240,
    parameter int unsigned BOUNCE_LIMIT = 64,
    parameter int unsigned BOUNCE_STEP  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             trigger,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             active,
    input  logic [RGB_W-1:0] bg_rgb,
    output logic [9:0]       em_x,
    output logic [9:0]       em_y,
    output logic             em_active,
    input  logic             em_draw,
    input  logic [RGB_W-1:0] em_rgb,
    output logic [RGB_W-1:0] pix_rgb,
    output logic             busy,
    output logic [1:0]       level
);

    localparam logic [1:0] StIdle    = 2'(EmIdle);
    localparam logic [1:0] StFadeIn  = 2'(EmFadeIn);
    localparam logic [1:0] StHold    = 2'(EmHold);
    localparam logic [1:0] StFadeOut = 2'(EmFadeOut);

    localparam logic [7:0] FadeLast = 8'(FADE_FRAMES - 1);
    localparam logic [7:0] HoldLast = 8'(HOLD_FRAMES - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       level_q, level_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d, pend_eff;
    logic [RGB_W-1:0] pix_q, pix_d;
    logic             busy_q;
    logic signed [8:0] off_x;

    // Sequencer next state; a trigger in the same cycle counts as pending.
    always_comb begin
        pend_eff = pend_q | trigger;
        state_d  = state_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        pend_d   = pend_eff;
        if (frame_start) begin
            case (state_q)
                StIdle: begin
                    if (pend_eff) begin
                        state_d = StFadeIn;
                        level_d = 2'd1;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end
                end
                StFadeIn: begin
                    if (cnt_q == FadeLast) begin
                        cnt_d = '0;
                        if (level_q == 2'd3) begin
                            state_d = StHold;
                        end else begin
                            level_d = level_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == HoldLast) begin
                        state_d = StFadeOut;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    // Retrigger resumes fading in from the current level.
                    if (pend_eff) begin
                        state_d = StFadeIn;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                    end else if (cnt_q == FadeLast) begin
                        cnt_d   = '0;
                        level_d = level_q - 2'd1;
                        if (level_q == 2'd1) begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    // Fade-and-mix of the generator output over the background.
    always_comb begin
        pix_d = '0;
        if (active) begin
            pix_d = (em_draw && (level_q != 2'd0)) ? rgb_fade(em_rgb, level_q) : bg_rgb;
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            level_q <= 2'd0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pix_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pix_q   <= pix_d;
            busy_q  <= (state_d != StIdle);
        end
    end

`ifdef EMBLEM_CTRL_BOUNCE_EN
    logic bounce_en, bounce_clr;

    assign bounce_en  = frame_start && (state_q == StHold);
    assign bounce_clr = frame_start && (state_q != StIdle) && (state_d == StIdle);

    emblem_bounce #(
        .BOUNCE_LIMIT (BOUNCE_LIMIT),
        .BOUNCE_STEP  (BOUNCE_STEP)
    ) u_bounce (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bounce_en),
        .clr   (bounce_clr),
        .off_x (off_x)
    );
`else
    assign off_x = '0;
`endif

    assign em_x      = x - {off_x[8], off_x};
    assign em_y      = y;
    assign em_active = active && (level_q != 2'd0);
    assign pix_rgb   = pix_q;
    assign busy      = busy_q;
    assign level     = level_q;

endmodule

// File: tb/tb_emblem_ctrl.sv
// Self-checking bench for emblem_ctrl: a frame-level reference model runs
// alongside the DUT under random pixel/trigger stimulus plus directed cases.
module tb_emblem_ctrl;

    localparam int F = 2;
    localparam int H = 7;
    localparam int L = 4;
    localparam int S = 3;

    localparam int M_IDLE = 0;
    localparam int M_IN   = 1;
    localparam int M_HOLD = 2;
    localparam int M_OUT  = 3;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       trigger;
    logic       trigger_def;
    logic [9:0] x, y;
    logic       active;
    logic [5:0] bg_rgb;
    logic       em_draw;
    logic [5:0] em_rgb;

    logic [9:0] em_x, em_y;
    logic       em_active;
    logic [5:0] pix_rgb;
    logic       busy;
    logic [1:0] level;

    logic [9:0] em_x_def, em_y_def;
    logic       em_active_def;
    logic [5:0] pix_rgb_def;
    logic       busy_def;
    logic [1:0] level_def;

    int n_cmp = 0;
    int n_bad = 0;

    bit rnd_pix  = 0;
    bit rnd_trig = 0;

    // Reference model state
    int m_state, m_level, m_cnt, m_off, m_dir, m_pix;
    bit m_pend;

    emblem_ctrl #(
        .FADE_FRAMES  (F),
        .HOLD_FRAMES  (H),
        .BOUNCE_LIMIT (L),
        .BOUNCE_STEP  (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .trigger     (trigger),
        .x           (x),
        .y           (y),
        .active      (active),
        .bg_rgb      (bg_rgb),
        .em_x        (em_x),
        .em_y        (em_y),
        .em_active   (em_active),
        .em_draw     (em_draw),
        .em_rgb      (em_rgb),
        .pix_rgb     (pix_rgb),
        .busy        (busy),
        .level       (level)
    );

    emblem_ctrl dut_def (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .trigger     (trigger_def),
        .x           (x),
        .y           (y),
        .active      (active),
        .bg_rgb      (bg_rgb),
        .em_x        (em_x_def),
        .em_y        (em_y_def),
        .em_active   (em_active_def),
        .em_draw     (em_draw),
        .em_rgb      (em_rgb),
        .pix_rgb     (pix_rgb_def),
        .busy        (busy_def),
        .level       (level_def)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int fade_ref(input int rgb, input int lvl);
        int res = 0;
        for (int ch = 0; ch < 3; ch++) begin
            int c = (rgb >> (2 * ch)) & 3;
            res |= ((c < lvl) ? c : lvl) << (2 * ch);
        end
        return res;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_level = 0; m_cnt = 0; m_off = 0; m_dir = 1;
        m_pix = 0; m_pend = 0;
    endtask

    // One clock of the reference model, using the inputs present at the edge.
    task automatic model_step();
        bit pe = m_pend || trigger;
        bit nxt_pend = pe;
        m_pix = active ? ((em_draw && m_level != 0) ? fade_ref(int'(em_rgb), m_level)
                                                     : int'(bg_rgb)) : 0;
        if (frame_start) begin
            case (m_state)
                M_IDLE: if (pe) begin
                    m_state = M_IN; m_level = 1; m_cnt = 0; nxt_pend = 0;
                end
                M_IN: begin
                    if (m_cnt == F - 1) begin
                        m_cnt = 0;
                        if (m_level == 3) m_state = M_HOLD;
                        else m_level++;
                    end else m_cnt++;
                end
                M_HOLD: begin
`ifdef EMBLEM_CTRL_BOUNCE_EN
                    m_off += m_dir * S;
                    if (m_off > L) begin m_off = L; m_dir = -m_dir; end
                    else if (m_off < -L) begin m_off = -L; m_dir = -m_dir; end
`endif
                    if (m_cnt == H - 1) begin m_state = M_OUT; m_cnt = 0; end
                    else m_cnt++;
                end
                default: begin
                    if (pe) begin
                        m_state = M_IN; m_cnt = 0; nxt_pend = 0;
                    end else if (m_cnt == F - 1) begin
                        m_cnt = 0;
                        m_level--;
                        if (m_level == 0) begin
                            m_state = M_IDLE; m_off = 0; m_dir = 1;
                        end
                    end else m_cnt++;
                end
            endcase
        end
        m_pend = nxt_pend;
    endtask

    task automatic compare_all();
        check_eq("level", int'(level), m_level);
        check_eq("busy", int'(busy), int'(m_state != M_IDLE));
        check_eq("pix_rgb", int'(pix_rgb), m_pix);
        check_eq("em_x", int'(em_x), (int'(x) - m_off) & 1023);
        check_eq("em_y", int'(em_y), int'(y));
        check_eq("em_active", int'(em_active), int'(active && m_level != 0));
    endtask

    task automatic cyc();
        if (rnd_pix) begin
            x       = 10'($urandom_range(0, 1023));
            y       = 10'($urandom_range(0, 1023));
            active  = 1'($urandom_range(0, 1));
            bg_rgb  = 6'($urandom_range(0, 63));
            em_draw = 1'($urandom_range(0, 1));
            em_rgb  = 6'($urandom_range(0, 63));
        end
        if (rnd_trig) trigger = ($urandom_range(0, 9) == 0);
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic frame_pulse(input int gap);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        repeat (gap) cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lv[5] = '{1, 1, 2, 2, 3};
        int offs[6]   = '{3, 4, 1, -2, -4, -1};
        int nb;

        rst_n = 1'b0; frame_start = 0; trigger = 0; trigger_def = 0;
        x = 0; y = 0; active = 0; bg_rgb = 0; em_draw = 0; em_rgb = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Fade-in with FADE_FRAMES = 2
        trigger = 1; cyc(); trigger = 0;
        for (int i = 0; i < 5; i++) begin
            frame_pulse(1);
            check_eq("fadein_level", int'(level), exp_lv[i]);
            check_eq("fadein_busy", int'(busy), 1);
        end
        frame_pulse(1);
        frame_pulse(1);

        // HOLD: bounce offsets observed through em_x with x fixed at 2
        x = 10'd2; active = 1;
        for (int i = 0; i < 6; i++) begin
            frame_pulse(1);
`ifdef EMBLEM_CTRL_BOUNCE_EN
            check_eq("bounce_em_x", int'(em_x), (2 - offs[i]) & 1023);
`else
            check_eq("bounce_em_x", int'(em_x), 2 + 0 * offs[i]);
`endif
            check_eq("hold_level", int'(level), 3);
        end

        // Async reset mid-HOLD takes effect without a clock edge
        em_draw = 1; em_rgb = 6'h3f; cyc();
        check_eq("pre_reset_pix", int'(pix_rgb), 63);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_level", int'(level), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_pix", int'(pix_rgb), 0);
        check_eq("rst_em_x", int'(em_x), 2);
        check_eq("rst_em_active", int'(em_active), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all();
        trigger = 1; cyc(); trigger = 0;
        frame_pulse(2);
        check_eq("restart_level", int'(level), 1);

        // Mix at level 1
        active = 1; em_draw = 1; em_rgb = 6'b110110; bg_rgb = 6'b000011;
        cyc();
        check_eq("mix_fade", int'(pix_rgb), 6'b010101);
        em_draw = 0; cyc();
        check_eq("mix_bg", int'(pix_rgb), 3);
        active = 0; cyc();
        check_eq("mix_inactive", int'(pix_rgb), 0);

        // Retrigger in FADE_OUT at level 2
        for (int i = 0; i < 100 && !(m_state == M_OUT && m_level == 2); i++) frame_pulse(1);
        check_eq("fadeout_level", int'(level), 2);
        check_eq("fadeout_busy", int'(busy), 1);
        trigger = 1; cyc(); trigger = 0;
        frame_pulse(1);
        check_eq("retrig_level", int'(level), 2);
        frame_pulse(1);
        frame_pulse(1);
        check_eq("retrig_up", int'(level), 3);

        // Random traffic
        rnd_pix = 1; rnd_trig = 1;
        for (int i = 0; i < 80; i++) frame_pulse($urandom_range(0, 3));
        rnd_trig = 0; trigger = 0;

        // Full cycle with default parameters
        trigger_def = 1; cyc(); trigger_def = 0;
        nb = 0;
        for (int i = 0; i < 400; i++) begin
            frame_pulse(1);
            if (busy_def) nb++;
            else if (nb > 0) break;
        end
        check_eq("full_cycle_frames", nb, 288);
        check_eq("full_cycle_level", int'(level_def), 0);
        check_eq("full_cycle_em_x", int'(em_x_def), int'(x));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
